// File: rtl/mask_renderer.sv
// Segment-mask renderer: loads run-length segment records from the ioctl byte stream into a
// record RAM and walks them in raster order. Optional feature macro: MASK_ACTIVE_GATE_EN.
module mask_renderer #(
  parameter int CLOCK_RATIO  = 3,
  parameter int COORD_WIDTH  = 10,
  parameter int ID_WIDTH     = 10,
  parameter int LENGTH_WIDTH = 10,
  parameter int ADDR_WIDTH   = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ioctl_wr,
  input  logic [15:0]            ioctl_dout,
  input  logic                   vblank,
  input  logic                   hblank,
  input  logic [COORD_WIDTH-1:0] video_x,
  input  logic [COORD_WIDTH-1:0] video_y,
`ifdef MASK_ACTIVE_GATE_EN
  input  logic                   segment_active,
`endif
  output logic [ID_WIDTH-1:0]    segment_id,
  output logic                   has_segment,
  output logic [ADDR_WIDTH:0]    records_loaded,
  output logic                   table_end
);

  localparam int RECORD_BITS  = LENGTH_WIDTH + 2 * COORD_WIDTH + ID_WIDTH;
  localparam int RECORD_BYTES = (RECORD_BITS + 7) / 8;
  localparam int CNT_W        = $clog2(RECORD_BYTES + 1);
  localparam int VC_W         = $clog2(CLOCK_RATIO);
  localparam logic [ADDR_WIDTH:0]   DEPTH_C   = (ADDR_WIDTH + 1)'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {LD_IDLE, LD_LO, LD_HI} ld_state_t;

  ld_state_t                 ld_state, ld_next;
  logic [15:0]               word_q;
  logic                      take_byte;
  logic [7:0]                byte_in;
  logic [CNT_W-1:0]          byte_cnt;
  logic [RECORD_BYTES*8-1:0] rec_buf, buf_next;
  logic                      last_byte;
  logic [RECORD_BITS-1:0]    wr_data;
  logic                      wr_pend, inc_pend, ram_we;
  logic [ADDR_WIDTH-1:0]     write_addr;

  logic [RECORD_BITS-1:0]    ram [1 << ADDR_WIDTH];
  logic [RECORD_BITS-1:0]    rec_q;

  logic [VC_W-1:0]           vid_counter;
  logic                      strobe;
  // One bit wider than the RAM index so the pointer can sit past a completely full table.
  logic [ADDR_WIDTH:0]       read_addr;
  logic                      in_segment, run_flag;
  logic [LENGTH_WIDTH-1:0]   remaining;

  logic [ID_WIDTH-1:0]       rec_id;
  logic [COORD_WIDTH-1:0]    rec_x, rec_y;
  logic [LENGTH_WIDTH-1:0]   rec_len;
  logic                      match;

  // Byte sequencer: low byte of a latched word goes out first, high byte the cycle after.
  always_ff @(posedge clk) begin
    if (reset) ld_state <= LD_IDLE;
    else       ld_state <= ld_next;
  end

  always_comb begin
    ld_next   = ld_state;
    take_byte = 1'b0;
    byte_in   = word_q[7:0];
    case (ld_state)
      LD_IDLE: if (ioctl_wr) ld_next = LD_LO;
      LD_LO: begin
        take_byte = 1'b1;
        byte_in   = word_q[7:0];
        ld_next   = LD_HI;
      end
      LD_HI: begin
        take_byte = 1'b1;
        byte_in   = word_q[15:8];
        ld_next   = ioctl_wr ? LD_LO : LD_IDLE;
      end
      default: ld_next = LD_IDLE;
    endcase
  end

  always_comb begin
    buf_next = rec_buf;
    for (int unsigned i = 0; i < RECORD_BYTES; i++) begin
      if (byte_cnt == CNT_W'(i)) buf_next[i*8 +: 8] = byte_in;
    end
  end

  assign last_byte = take_byte && (byte_cnt == CNT_W'(RECORD_BYTES - 1));
  assign ram_we    = wr_pend && (records_loaded != DEPTH_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q         <= '0;
      rec_buf        <= '0;
      byte_cnt       <= '0;
      wr_data        <= '0;
      wr_pend        <= 1'b0;
      inc_pend       <= 1'b0;
      write_addr     <= '0;
      records_loaded <= '0;
    end else begin
      if (ioctl_wr && ld_state != LD_LO) word_q <= ioctl_dout;
      if (take_byte) begin
        rec_buf  <= buf_next;
        byte_cnt <= last_byte ? '0 : byte_cnt + CNT_W'(1);
      end
      // The completed record is captured whole so the next record can start filling at once.
      if (last_byte) wr_data <= buf_next[RECORD_BITS-1:0];
      wr_pend  <= last_byte;
      inc_pend <= ram_we;
      if (inc_pend) begin
        records_loaded <= records_loaded + (ADDR_WIDTH + 1)'(1);
        if (write_addr != LAST_ADDR) write_addr <= write_addr + ADDR_WIDTH'(1);
      end
    end
  end

  // Single-port record RAM; a pending write steals the port from the render read.
  always_ff @(posedge clk) begin
    if (ram_we) ram[write_addr] <= wr_data;
    else        rec_q <= ram[read_addr[ADDR_WIDTH-1:0]];
  end

  assign rec_id  = rec_q[ID_WIDTH-1:0];
  assign rec_x   = rec_q[ID_WIDTH +: COORD_WIDTH];
  assign rec_y   = rec_q[ID_WIDTH + COORD_WIDTH +: COORD_WIDTH];
  assign rec_len = rec_q[ID_WIDTH + 2*COORD_WIDTH +: LENGTH_WIDTH];

  assign match     = (video_x == rec_x) && (video_y == rec_y);
  assign table_end = (read_addr >= records_loaded) || (rec_len == '0);
  assign strobe    = (vid_counter == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      vid_counter <= '0;
      read_addr   <= '0;
      in_segment  <= 1'b0;
      run_flag    <= 1'b0;
      remaining   <= '0;
      segment_id  <= '0;
    end else begin
      vid_counter <= strobe ? VC_W'(CLOCK_RATIO - 1) : vid_counter - VC_W'(1);
      if (vblank) begin
        read_addr  <= '0;
        in_segment <= 1'b0;
        run_flag   <= 1'b0;
      end else if (hblank) begin
        in_segment <= 1'b0;
        run_flag   <= 1'b0;
      end else if (strobe) begin
        segment_id <= rec_id;
        if (!table_end && match) begin
          run_flag   <= 1'b1;
          remaining  <= rec_len - LENGTH_WIDTH'(1);
          in_segment <= (rec_len != LENGTH_WIDTH'(1));
          if (rec_len == LENGTH_WIDTH'(1)) read_addr <= read_addr + (ADDR_WIDTH + 1)'(1);
        end else if (in_segment) begin
          run_flag   <= 1'b1;
          remaining  <= remaining - LENGTH_WIDTH'(1);
          in_segment <= (remaining != LENGTH_WIDTH'(1));
          if (remaining == LENGTH_WIDTH'(1) && !table_end)
            read_addr <= read_addr + (ADDR_WIDTH + 1)'(1);
        end else begin
          run_flag <= 1'b0;
        end
      end
    end
  end

`ifdef MASK_ACTIVE_GATE_EN
  // segment_active answers for the segment_id issued on the previous clk.
  logic strobe_d, has_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_d <= 1'b0;
      has_q    <= 1'b0;
    end else begin
      strobe_d <= strobe && !vblank && !hblank;
      if (vblank || hblank) has_q <= 1'b0;
      else if (strobe_d)    has_q <= run_flag && segment_active;
    end
  end

  assign has_segment = has_q;
`else
  assign has_segment = run_flag;
`endif

endmodule

// File: tb/tb_mask_renderer.sv
// Self-checking bench for mask_renderer: table-driven pixel sweeps with a scoreboard queue,
// plus hand-written load/reset sequences.
module tb_mask_renderer;

  localparam int CR = 3;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_wr = 1'b0;
  logic [15:0]   ioctl_dout = '0;
  logic          vblank = 1'b0;
  logic          hblank = 1'b0;
  logic [9:0]    video_x = 10'd1000;
  logic [9:0]    video_y = 10'd1000;
  logic          segment_active = 1'b1;
  logic [9:0]    segment_id;
  logic          has_segment;
  logic [AW:0]   records_loaded;
  logic          table_end;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mask_renderer #(.CLOCK_RATIO(CR), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
    .vblank(vblank), .hblank(hblank), .video_x(video_x), .video_y(video_y),
`ifdef MASK_ACTIVE_GATE_EN
    .segment_active(segment_active),
`endif
    .segment_id(segment_id), .has_segment(has_segment),
    .records_loaded(records_loaded), .table_end(table_end)
  );

  // Free-running pixel phase, restarted by reset.
  int tb_cnt = 0;
  always @(posedge clk) begin
    if (reset) tb_cnt <= 0;
    else       tb_cnt <= (tb_cnt == 0) ? CR - 1 : tb_cnt - 1;
  end

  typedef struct {
    logic [9:0] x, y;
    logic       hb, vb;
    logic       exp_has;
    logic [9:0] exp_id;
    logic       chk_id;
    logic       exp_te;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  logic [7:0] bq[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void v(input int x, input int y, input bit hb, input bit vb,
                            input bit has, input int id, input bit chk, input bit te);
    vec_t e;
    e.x = 10'(x); e.y = 10'(y); e.hb = hb; e.vb = vb;
    e.exp_has = has; e.exp_id = 10'(id); e.chk_id = chk; e.exp_te = te;
    vecs.push_back(e);
  endfunction

  function automatic void add_rec(input int id, input int x, input int y, input int len);
    logic [39:0] r;
    r = {10'(len), 10'(y), 10'(x), 10'(id)};
    for (int i = 0; i < 5; i++) bq.push_back(r[i*8 +: 8]);
  endfunction

  task automatic write_word(input logic [15:0] w);
    @(negedge clk); ioctl_wr = 1'b1; ioctl_dout = w;
    @(negedge clk); ioctl_wr = 1'b0;
  endtask

  task automatic flush_load();
    logic [15:0] w;
    while (bq.size() > 0) begin
      w[7:0]  = bq.pop_front();
      w[15:8] = (bq.size() > 0) ? bq.pop_front() : 8'h00;
      write_word(w);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; vblank = 1'b0; hblank = 1'b0; video_x = 10'd1000; video_y = 10'd1000;
    segment_active = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_strobe(input string tag);
    bit s, seen;
    seen = 1'b0;
    for (int k = 0; k < CR + 2; k++) begin
      s = (tb_cnt == 0) && !reset;
      @(posedge clk); #1;
      if (s) begin seen = 1'b1; break; end
    end
    if (!seen) check({tag, " strobe timeout"}, 0, 1);
  endtask

  task automatic step(input vec_t e);
    vec_t got;
    string tag;
    video_x = e.x; video_y = e.y; hblank = e.hb; vblank = e.vb;
    sb.push_back(e);
    tag = $sformatf("px(%0d,%0d,hb%0d,vb%0d)", e.x, e.y, e.hb, e.vb);
    wait_strobe(tag);
    @(posedge clk); #1;
    got = sb.pop_front();
    check({tag, " has_segment"}, has_segment, got.exp_has);
    if (got.chk_id) check({tag, " segment_id"}, segment_id, got.exp_id);
    check({tag, " table_end"}, table_end, got.exp_te);
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);
    vecs.delete();
    hblank = 1'b0; vblank = 1'b0; video_x = 10'd1000; video_y = 10'd1000;
  endtask

  initial begin
    // Reset state, checked while reset is still held.
    repeat (3) @(negedge clk);
    check("reset segment_id", segment_id, 0);
    check("reset has_segment", has_segment, 0);
    check("reset records_loaded", records_loaded, 0);
    check("reset table_end", table_end, 1);
    reset = 1'b0;

    // End sentinel: id=0x201 x=0x100 y=0x140 len=0 (the sixth byte starts an unfinished record).
    write_word(16'h0201);
    write_word(16'h1404);
    write_word(16'h0000);
    repeat (8) @(negedge clk);
    check("sentinel records_loaded", records_loaded, 1);
    check("sentinel table_end", table_end, 1);
    v(10'h100, 10'h140, 0, 0, 0, 10'h201, 1, 1);
    run_vecs();

    // Single run id7 at (10,4) length 3.
    do_reset();
    add_rec(7, 10, 4, 3);
    flush_load();
    check("run3 records_loaded", records_loaded, 1);
    v(10, 3, 0, 0, 0, 7, 1, 0);
    v( 8, 4, 0, 0, 0, 7, 1, 0);
    v( 9, 4, 0, 0, 0, 7, 1, 0);
    v(10, 4, 0, 0, 1, 7, 1, 0);
    v(11, 4, 0, 0, 1, 7, 1, 0);
    v(12, 4, 0, 0, 1, 7, 1, 1);
    v(13, 4, 0, 0, 0, 0, 0, 1);
    v(14, 4, 0, 0, 0, 0, 0, 1);
    run_vecs();

    // Back-to-back records on one line.
    do_reset();
    add_rec(1, 5, 2, 2);
    add_rec(2, 7, 2, 1);
    flush_load();
    check("b2b records_loaded", records_loaded, 2);
    v(4, 2, 0, 0, 0, 1, 1, 0);
    v(5, 2, 0, 0, 1, 1, 1, 0);
    v(6, 2, 0, 0, 1, 1, 1, 0);
    v(7, 2, 0, 0, 1, 2, 1, 1);
    v(8, 2, 0, 0, 0, 0, 0, 1);
    v(9, 2, 0, 0, 0, 0, 0, 1);
    run_vecs();

    // Run truncated by hblank; pointer is held, so the next line finds no start until vblank rewinds.
    do_reset();
    add_rec(3, 1020, 6, 8);
    add_rec(4, 2, 7, 2);
    flush_load();
    v(1019, 6, 0, 0, 0, 3, 1, 0);
    v(1020, 6, 0, 0, 1, 3, 1, 0);
    v(1021, 6, 0, 0, 1, 3, 1, 0);
    v(1022, 6, 0, 0, 1, 3, 1, 0);
    v(1023, 6, 0, 0, 1, 3, 1, 0);
    v(   0, 6, 1, 0, 0, 3, 1, 0);
    v(   1, 7, 0, 0, 0, 3, 1, 0);
    v(   2, 7, 0, 0, 0, 3, 1, 0);
    v(   3, 7, 0, 0, 0, 3, 1, 0);
    v(   0, 0, 0, 1, 0, 3, 1, 0);
    v(1020, 6, 0, 0, 1, 3, 1, 0);
    v(1021, 6, 0, 0, 1, 3, 1, 0);
    run_vecs();

    // Reset in the middle of a record discards the partial bytes.
    do_reset();
    write_word(16'hAAAA);
    repeat (3) @(negedge clk);
    do_reset();
    add_rec(9, 3, 1, 1);
    flush_load();
    check("midreset records_loaded", records_loaded, 1);
    v(2, 1, 0, 0, 0, 9, 1, 0);
    v(3, 1, 0, 0, 1, 9, 1, 1);
    v(4, 1, 0, 0, 0, 0, 0, 1);
    run_vecs();

    // Table full: two extra records are dropped and must not overwrite the last slot.
    do_reset();
    add_rec(10, 1, 9, 1);
    add_rec(11, 2, 9, 1);
    add_rec(12, 3, 9, 1);
    add_rec(13, 4, 9, 1);
    add_rec(14, 4, 9, 1);
    add_rec(15, 4, 9, 1);
    flush_load();
    check("full records_loaded", records_loaded, 4);
    v(0, 9, 0, 0, 0, 10, 1, 0);
    v(1, 9, 0, 0, 1, 10, 1, 0);
    v(2, 9, 0, 0, 1, 11, 1, 0);
    v(3, 9, 0, 0, 1, 12, 1, 0);
    v(4, 9, 0, 0, 1, 13, 1, 1);
    v(5, 9, 0, 0, 0, 0, 0, 1);
    run_vecs();

`ifdef MASK_ACTIVE_GATE_EN
    // Inactive segment: mask suppressed, walking unchanged.
    do_reset();
    add_rec(7, 10, 4, 3);
    flush_load();
    segment_active = 1'b0;
    v( 9, 4, 0, 0, 0, 7, 1, 0);
    v(10, 4, 0, 0, 0, 7, 1, 0);
    v(11, 4, 0, 0, 0, 7, 1, 0);
    v(12, 4, 0, 0, 0, 7, 1, 1);
    v(13, 4, 0, 0, 0, 0, 0, 1);
    run_vecs();
    segment_active = 1'b1;
`endif

    if (sb.size() != 0) check("scoreboard drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
